// File: rtl/d_grf_sb.sv
// Register file with write-through read ports and a per-register pending-write
// scoreboard that D-stage hazard logic uses to stall on in-flight producers.

module d_grf_sb_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]                          addr_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]         regs_i,
  input  logic [(1<<ADDR_W)-1:0][CNT_W-1:0]          cnt_i,
  input  logic                                       we_i,
  input  logic                                       clr_i,
  input  logic [ADDR_W-1:0]                          wa_i,
  input  logic [DATA_W-1:0]                          wd_i,
  output logic [DATA_W-1:0]                          data_o,
  output logic                                       busy_o
);
  logic              zero, hit, ret;
  logic [CNT_W-1:0]  cnt_r, left;

  assign zero  = (ZERO_REG != 0) && (addr_i == '0);
  assign hit   = (addr_i == wa_i);
  assign cnt_r = cnt_i[addr_i];
  // A retirement landing this cycle already hides the producer, matching the bypassed data.
  assign ret   = clr_i && hit && (cnt_r != '0);
  assign left  = cnt_r - CNT_W'(ret);

  assign busy_o = !zero && (left != '0);
  assign data_o = zero ? '0 : ((we_i && hit) ? wd_i : regs_i[addr_i]);
endmodule

module d_grf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          wa_i,
  input  logic [DATA_W-1:0]          wd_i,
  input  logic                       wb_clr_i,
  input  logic                       mark_en_i,
  input  logic [ADDR_W-1:0]          mark_addr_i,
  input  logic                       flush_i,
  output logic [1:0]                 err_o
);
  localparam int               DEPTH = 1 << ADDR_W;
  localparam bit               ZR    = (ZERO_REG != 0);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]                   err_q, err_d;
  logic                         wr_en, clr_eff, ovf, unf, inc, dec;

  // Reset held low masks the bypass and retirement paths so reads stay at zero.
  assign wr_en   = we_i && reset_i && !(ZR && (wa_i == '0));
  assign clr_eff = wb_clr_i && reset_i;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    d_grf_sb_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr_i (rd_addr_i[i*ADDR_W +: ADDR_W]),
      .regs_i (regs_q),
      .cnt_i  (cnt_q),
      .we_i   (wr_en),
      .clr_i  (clr_eff),
      .wa_i   (wa_i),
      .wd_i   (wd_i),
      .data_o (rd_data_o[i*DATA_W +: DATA_W]),
      .busy_o (rd_busy_o[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        inc = mark_en_i && (mark_addr_i == ADDR_W'(r));
        dec = wb_clr_i  && (wa_i        == ADDR_W'(r));
        if (!(ZR && r == 0)) begin
          if (inc && !dec) begin
            if (cnt_q[r] == CMAX) ovf = 1'b1;
            else                  cnt_d[r] = cnt_q[r] + 1'b1;
          end else if (dec && !inc) begin
            if (cnt_q[r] == '0)   unf = 1'b1;
            else                  cnt_d[r] = cnt_q[r] - 1'b1;
          end
        end
      end
    end
    err_d = err_q | {unf, ovf};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      regs_q <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (wr_en) regs_q[wa_i] <= wd_i;
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_d_grf_sb.sv
// Directed bench for d_grf_sb: a reference model of the register file and
// scoreboard is checked every cycle, plus literal expectations per scenario.

module tb_d_grf_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we, wb_clr, mark_en, flush;
  logic [4:0]  wa, mark_addr;
  logic [31:0] wd;
  logic [1:0]  err;

  d_grf_sb dut (
    .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .we_i(we), .wa_i(wa), .wd_i(wd), .wb_clr_i(wb_clr),
    .mark_en_i(mark_en), .mark_addr_i(mark_addr), .flush_i(flush), .err_o(err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  bit          chk = 0;
  logic [31:0] mem [32];
  int          cnt [32];
  logic [1:0]  merr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin mem[r] = 0; cnt[r] = 0; end
    merr = 2'b00;
  endtask

  initial model_clear();
  always @(negedge reset) model_clear();

  // Model state advance at the clock edge, straight from the operation rules.
  always @(posedge clk) if (reset === 1'b1) begin
    if (we && wa != 0) mem[wa] = wd;
    if (flush) begin
      for (int r = 0; r < 32; r++) cnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit i_, d_;
        i_ = mark_en && (mark_addr == r);
        d_ = wb_clr && (wa == r);
        if (i_ && !d_) begin
          if (cnt[r] == 3) merr[0] = 1'b1; else cnt[r]++;
        end else if (d_ && !i_) begin
          if (cnt[r] == 0) merr[1] = 1'b1; else cnt[r]--;
        end
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) if (chk) begin
    for (int i = 0; i < 2; i++) begin
      int a, c;
      logic [31:0] ed;
      a  = rd_addr[i*5 +: 5];
      ed = (a == 0) ? 32'h0 : ((reset && we && wa == a) ? wd : mem[a]);
      c  = cnt[a];
      if (reset && wb_clr && wa == a && c > 0) c--;
      check($sformatf("model rd_data[%0d]", i), rd_data[i*32 +: 32], ed);
      check($sformatf("model rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, (a != 0 && c != 0)});
    end
    check("model err", {30'b0, err}, {30'b0, merr});
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    we = 0; wb_clr = 0; mark_en = 0; flush = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    reset = 0; idle(); wa = 0; wd = 0; mark_addr = 0; rd(0, 0);
    #1 chk = 1;
    // reset held: writes ignored
    we = 1; wa = 3; wd = 32'hDEADBEEF; rd(3, 3);
    #1 check("reset bypass", rd_data[31:0], 32'h0);
    tick(); tick();
    check("reset hold r3", rd_data[63:32], 32'h0);
    reset = 1; idle();
    #1 check("post-reset r3", rd_data[31:0], 32'h0);
    check("post-reset err", {30'b0, err}, 32'h0);
    we = 1; wa = 0; wd = 32'h1234; rd(0, 0);
    #1 check("r0 bypass", rd_data[31:0], 32'h0);
    tick(); idle();
    #1 check("r0 stored", rd_data[63:32], 32'h0);
    mark_en = 1; mark_addr = 0; tick(); idle();
    #1 check("r0 busy", {30'b0, rd_busy}, 32'h0);

    // write-through
    we = 1; wa = 5; wd = 32'hA5A5A5A5; rd(5, 5);
    #1 check("wt p0", rd_data[31:0], 32'hA5A5A5A5);
    check("wt p1", rd_data[63:32], 32'hA5A5A5A5);
    tick(); idle();
    #1 check("array p0", rd_data[31:0], 32'hA5A5A5A5);
    check("array p1", rd_data[63:32], 32'hA5A5A5A5);

    // scoreboard basic
    rd(7, 7); mark_en = 1; mark_addr = 7;
    #1 check("mark same cycle", {30'b0, rd_busy}, 32'h0);
    tick(); idle();
    #1 check("busy after mark", {30'b0, rd_busy}, 32'h3);
    tick(); tick();
    we = 1; wb_clr = 1; wa = 7; wd = 32'h77;
    #1 check("retire busy", {30'b0, rd_busy}, 32'h0);
    check("retire data", rd_data[31:0], 32'h77);
    tick(); idle();
    #1 check("r7 stored", rd_data[63:32], 32'h77);

    // multiple outstanding
    rd(9, 9); mark_en = 1; mark_addr = 9;
    tick(); tick(); tick(); idle();
    #1 check("3 marks busy", {30'b0, rd_busy}, 32'h3);
    check("3 marks err", {30'b0, err}, 32'h0);
    mark_en = 1; mark_addr = 9; tick(); idle();
    #1 check("overflow err", {30'b0, err}, 32'h1);
    wb_clr = 1; wa = 9; tick(); tick();
    #1 check("2 retire busy", {30'b0, rd_busy}, 32'h0);
    tick(); idle();
    #1 check("drained busy", {30'b0, rd_busy}, 32'h0);
    check("no underflow yet", {30'b0, err}, 32'h1);
    wb_clr = 1; wa = 9; tick(); idle();
    #1 check("underflow err", {30'b0, err}, 32'h3);

    // simultaneous mark/retire and flush
    rd(4, 6); mark_en = 1; mark_addr = 4; tick(); idle();
    mark_en = 1; mark_addr = 4; wb_clr = 1; wa = 4; tick(); idle();
    #1 check("mark+retire r4", {31'b0, rd_busy[0]}, 32'h1);
    mark_en = 1; mark_addr = 6; tick(); idle();
    #1 check("r4 r6 busy", {30'b0, rd_busy}, 32'h3);
    flush = 1; we = 1; wa = 6; wd = 32'h66; mark_en = 1; mark_addr = 4;
    tick(); idle();
    #1 check("flush busy", {30'b0, rd_busy}, 32'h0);
    check("flush r6", rd_data[63:32], 32'h66);
    check("flush err", {30'b0, err}, 32'h3);

    // async reset mid-cycle
    we = 1; wa = 2; wd = 32'h22; mark_en = 1; mark_addr = 2; tick(); idle();
    rd(2, 2);
    #1 check("r2 data", rd_data[31:0], 32'h22);
    check("r2 busy", {30'b0, rd_busy}, 32'h3);
    reset = 0;
    #1 check("async data", rd_data[63:32], 32'h0);
    check("async busy", {30'b0, rd_busy}, 32'h0);
    check("async err", {30'b0, err}, 32'h0);
    tick(); reset = 1;

    // top address, mixed ports
    rd(31, 2); we = 1; wa = 31; wd = 32'hFFFFFFFF; mark_en = 1; mark_addr = 31;
    tick(); idle();
    #1 check("r31", rd_data[31:0], 32'hFFFFFFFF);
    wb_clr = 1; wa = 31; tick(); idle();
    tick();
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
